uart_boot_ctrl: RTL

//  Hardware boot-load sequencer between the UART RX byte stream and the instruction/data memory bus.

---
 rtl/uart_boot_ctrl_if.sv | 29 ++
 rtl/uart_boot_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_ctrl_if.sv
// uart_boot_ctrl_if
//   Groups the UART RX byte stream and the memory write bus of the boot-load
//   sequencer.
//   master : the boot controller (consumes RX bytes, issues memory writes)
//   slave  : the environment (UART RX FIFO plus memory bus arbiter)
//   rx_data/rx_valid/rx_ready : byte stream, consumed on rx_valid & rx_ready
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : write request held until mem_gnt
//   mem_gnt : grant, transfer completes on mem_req & mem_gnt
interface uart_boot_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;

    modport master (
        input  rx_data, rx_valid, mem_gnt,
        output rx_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output rx_data, rx_valid, mem_gnt,
        input  rx_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/uart_boot_ctrl.sv
// uart_boot_ctrl
//   Boot-load sequencer. A run of STP_BYTE holds the CPU in reset and opens a
//   load: 4-byte LE start address, 4-byte LE byte count, then the payload is
//   packed into 32-bit words and written over the req/gnt bus. A run of
//   ON_BYTE releases the CPU. Misaligned address or an inter-byte timeout
//   sets the sticky err flag and parks in HALT.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   bus        : RX byte stream + memory write bus (master modport)
//   cpu_rst    : CPU reset hold, active high
//   busy       : 1 in any state other than RUN
//   err        : sticky error, cleared on entry to SYNC
module uart_boot_ctrl #(
    parameter logic [7:0]  STP_BYTE    = 8'h55,
    parameter logic [7:0]  ON_BYTE     = 8'hAA,
    parameter int unsigned STP_COUNT   = 32,
    parameter int unsigned ON_COUNT    = 32,
    parameter int unsigned TIMEOUT_CYC = 2000000,
    parameter bit          BOOT_ON_RST = 1'b0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    uart_boot_ctrl_if.master bus,
    output logic             cpu_rst,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {RUN, HALT, SYNC, ADDR, LEN, DATA, WR, WAIT_ON} state_t;

    localparam state_t      RST_STATE = BOOT_ON_RST ? HALT : RUN;
    localparam logic [7:0]  STP_N     = STP_COUNT[7:0];
    localparam logic [7:0]  ON_N      = ON_COUNT[7:0];
    localparam logic [31:0] TO_N      = TIMEOUT_CYC;

    state_t      state, state_nx;
    logic        cpu_rst_q, cpu_rst_nx;
    logic        err_q, err_nx;
    logic        req, req_nx;
    logic [31:0] addr, addr_nx;
    logic [31:0] wdata, wdata_nx;
    logic [3:0]  be, be_nx;
    logic [31:0] cnt, cnt_nx;
    logic [1:0]  idx, idx_nx;
    logic [7:0]  mark, mark_nx;
    logic [31:0] idle, idle_nx;
    logic        acc;
    logic [7:0]  mark_inc;
    logic [7:0]  rd;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= RST_STATE;
            cpu_rst_q <= BOOT_ON_RST;
            err_q     <= 1'b0;
            req       <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            be        <= '0;
            cnt       <= '0;
            idx       <= '0;
            mark      <= '0;
            idle      <= '0;
        end else begin
            state     <= state_nx;
            cpu_rst_q <= cpu_rst_nx;
            err_q     <= err_nx;
            req       <= req_nx;
            addr      <= addr_nx;
            wdata     <= wdata_nx;
            be        <= be_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            mark      <= mark_nx;
            idle      <= idle_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cpu_rst_nx = cpu_rst_q;
        err_nx     = err_q;
        req_nx     = req;
        addr_nx    = addr;
        wdata_nx   = wdata;
        be_nx      = be;
        cnt_nx     = cnt;
        idx_nx     = idx;
        mark_nx    = mark;
        idle_nx    = '0;
        rd         = bus.rx_data;
        acc        = bus.rx_valid && (state != WR);
        mark_inc   = (mark == 8'd255) ? 8'd255 : mark + 8'd1;

        // Idle counter only runs while a header or payload byte is awaited
        if (state inside {ADDR, LEN, DATA})
            idle_nx = acc ? 32'd0 : idle + 32'd1;

        case (state)
            RUN, HALT: begin
                if (acc) begin
                    if (rd == STP_BYTE) begin
                        if (mark_inc == STP_N) begin
                            state_nx   = SYNC;
                            cpu_rst_nx = 1'b1;
                            err_nx     = 1'b0;
                            mark_nx    = '0;
                            // Lanes may hold residue from an aborted load
                            wdata_nx   = '0;
                            be_nx      = '0;
                        end else begin
                            mark_nx = mark_inc;
                        end
                    end else begin
                        mark_nx = '0;
                    end
                end
            end
            SYNC: begin
                if (acc && rd != STP_BYTE) begin
                    addr_nx  = {24'h0, rd};
                    idx_nx   = 2'd1;
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                if (acc) begin
                    addr_nx[{idx, 3'b000} +: 8] = rd;
                    idx_nx = idx + 2'd1;
                    if (idx == 2'd3) begin
                        if (addr_nx[1:0] != 2'b00) begin
                            err_nx   = 1'b1;
                            state_nx = HALT;
                        end else begin
                            state_nx = LEN;
                        end
                    end
                end
            end
            LEN: begin
                if (acc) begin
                    cnt_nx[{idx, 3'b000} +: 8] = rd;
                    idx_nx = idx + 2'd1;
                    if (idx == 2'd3)
                        state_nx = (cnt_nx == 32'd0) ? WAIT_ON : DATA;
                end
            end
            DATA: begin
                if (acc) begin
                    wdata_nx[{idx, 3'b000} +: 8] = rd;
                    be_nx[idx] = 1'b1;
                    cnt_nx     = cnt - 32'd1;
                    idx_nx     = idx + 2'd1;
                    // Full word, or the last byte of the payload (partial tail)
                    if (idx == 2'd3 || cnt == 32'd1) begin
                        state_nx = WR;
                        req_nx   = 1'b1;
                    end
                end
            end
            WR: begin
                if (bus.mem_gnt) begin
                    addr_nx  = addr + 32'd4;
                    wdata_nx = '0;
                    be_nx    = '0;
                    req_nx   = 1'b0;
                    idx_nx   = '0;
                    mark_nx  = '0;
                    state_nx = (cnt != 32'd0) ? DATA : WAIT_ON;
                end
            end
            WAIT_ON: begin
                if (acc) begin
                    if (rd == ON_BYTE) begin
                        if (mark_inc == ON_N) begin
                            state_nx   = RUN;
                            cpu_rst_nx = 1'b0;
                            mark_nx    = '0;
                        end else begin
                            mark_nx = mark_inc;
                        end
                    end else begin
                        mark_nx = '0;
                    end
                end
            end
            default: state_nx = RST_STATE;
        endcase

        // Stream stalled too long inside a load: abandon it, CPU stays held
        if ((state inside {ADDR, LEN, DATA}) && !acc && (idle + 32'd1 == TO_N)) begin
            err_nx   = 1'b1;
            state_nx = HALT;
            mark_nx  = '0;
            idle_nx  = '0;
        end
    end

    assign bus.rx_ready  = (state != WR);
    assign bus.mem_req   = req;
    assign bus.mem_we    = req;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.mem_be    = be;
    assign cpu_rst       = cpu_rst_q;
    assign busy          = (state != RUN);
    assign err           = err_q;

endmodule
